// File: rtl/axis_pkt_framer.sv
// AXI-Stream framer: slices a sample flow into packets of cfg_len+1 words.
// Define AXIS_PKT_FRAMER_STATS_EN to build the stat_pkts/stat_short counters.
module axis_pkt_framer #(
  parameter int WIDTH    = 32,
  parameter int LEN_BITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LEN_BITS-1:0] cfg_len,
  input  logic [WIDTH-1:0]    s_rx_tdata,
  input  logic                s_rx_tvalid,
  input  logic                s_rx_tlast,
  output logic                s_rx_tready,
  output logic [WIDTH-1:0]    m_tx_tdata,
  output logic                m_tx_tvalid,
  output logic                m_tx_tlast,
  input  logic                m_tx_tready,
  output logic                in_pkt,
  output logic [15:0]         stat_pkts,
  output logic [15:0]         stat_short
);

  logic [LEN_BITS-1:0] cnt;
  logic [LEN_BITS-1:0] len_q;
  logic [LEN_BITS-1:0] eff;
  logic                acc;
  logic                eop;

  assign s_rx_tready = !m_tx_tvalid || m_tx_tready;
  assign acc         = s_rx_tvalid && s_rx_tready;
  assign eff         = (cnt == '0) ? cfg_len : len_q;
  assign eop         = s_rx_tlast || (cnt == eff);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      len_q       <= '0;
      in_pkt      <= 1'b0;
      m_tx_tdata  <= '0;
      m_tx_tlast  <= 1'b0;
      m_tx_tvalid <= 1'b0;
    end else if (acc) begin
      m_tx_tdata  <= s_rx_tdata;
      m_tx_tlast  <= eop;
      m_tx_tvalid <= 1'b1;
      in_pkt      <= !eop;
      cnt         <= eop ? '0 : cnt + 1'b1;
      if (cnt == '0)
        len_q <= cfg_len;
    end else if (m_tx_tready) begin
      m_tx_tvalid <= 1'b0;
    end
  end

`ifdef AXIS_PKT_FRAMER_STATS_EN
  logic short_hit;

  // Exact-length tlast (cnt == eff) is a normal close, not short.
  assign short_hit = s_rx_tlast && (cnt < eff);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_pkts  <= '0;
      stat_short <= '0;
    end else if (acc && eop) begin
      stat_pkts <= stat_pkts + 16'd1;
      if (short_hit)
        stat_short <= stat_short + 16'd1;
    end
  end
`else
  assign stat_pkts  = '0;
  assign stat_short = '0;
`endif

endmodule

// File: tb/tb_axis_pkt_framer.sv
// Self-checking bench for axis_pkt_framer.
// Stat expectations follow AXIS_PKT_FRAMER_STATS_EN.
module tb_axis_pkt_framer;
  localparam int W  = 32;
  localparam int LB = 5;
  localparam int LIMIT = 4000;

  logic          clk = 1'b0;
  logic          rst;
  logic [LB-1:0] cfg_len;
  logic [W-1:0]  s_rx_tdata;
  logic          s_rx_tvalid;
  logic          s_rx_tlast;
  logic          s_rx_tready;
  logic [W-1:0]  m_tx_tdata;
  logic          m_tx_tvalid;
  logic          m_tx_tlast;
  logic          m_tx_tready;
  logic          in_pkt;
  logic [15:0]   stat_pkts;
  logic [15:0]   stat_short;

  axis_pkt_framer #(.WIDTH(W), .LEN_BITS(LB)) dut (
    .clk(clk),
    .rst(rst),
    .cfg_len(cfg_len),
    .s_rx_tdata(s_rx_tdata),
    .s_rx_tvalid(s_rx_tvalid),
    .s_rx_tlast(s_rx_tlast),
    .s_rx_tready(s_rx_tready),
    .m_tx_tdata(m_tx_tdata),
    .m_tx_tvalid(m_tx_tvalid),
    .m_tx_tlast(m_tx_tlast),
    .m_tx_tready(m_tx_tready),
    .in_pkt(in_pkt),
    .stat_pkts(stat_pkts),
    .stat_short(stat_short)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  data;
    logic          src_last;
    logic [LB-1:0] len;
    logic          exp_last;
  } vec_t;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] st(int v);
`ifdef AXIS_PKT_FRAMER_STATS_EN
    return 16'(v);
`else
    return 16'd0;
`endif
  endfunction

  task automatic add(logic [W-1:0] d, logic sl, logic [LB-1:0] l, logic el);
    vec_t v;
    v.data = d;
    v.src_last = sl;
    v.len = l;
    v.exp_last = el;
    vecs.push_back(v);
  endtask

  // Drives the vector table, scoreboards outputs, checks latency/stall/in_pkt.
  task automatic run(bit rand_rdy);
    int           idx = 0;
    int           cyc = 0;
    bit           pacc = 0;
    bit           pstall = 0;
    logic         plast_exp = 0;
    logic [W-1:0] pdata = '0;
    logic         plast = 0;
    exp_t         e;
    while ((idx < vecs.size() || sb.size() != 0) && cyc < LIMIT) begin
      @(negedge clk);
      if (pacc) begin
        chk("lat_valid", 32'(m_tx_tvalid), 32'd1);
        chk("in_pkt", 32'(in_pkt), 32'(!plast_exp));
      end
      if (pstall) begin
        chk("stall_data", m_tx_tdata, pdata);
        chk("stall_last", 32'(m_tx_tlast), 32'(plast));
      end
      m_tx_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx < vecs.size()) begin
        s_rx_tvalid = 1'b1;
        s_rx_tdata  = vecs[idx].data;
        s_rx_tlast  = vecs[idx].src_last;
        cfg_len     = vecs[idx].len;
      end else begin
        s_rx_tvalid = 1'b0;
        s_rx_tlast  = 1'b0;
      end
      #1;
      chk("s_ready", 32'(s_rx_tready), 32'(!m_tx_tvalid || m_tx_tready));
      pstall = m_tx_tvalid && !m_tx_tready;
      pdata  = m_tx_tdata;
      plast  = m_tx_tlast;
      if (m_tx_tvalid && m_tx_tready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL extra_beat: got %0h want none", m_tx_tdata);
        end else begin
          e = sb.pop_front();
          if (m_tx_tdata !== e.data || m_tx_tlast !== e.last) begin
            bad++;
            $display("FAIL out_beat: got %0h/%0b want %0h/%0b",
                     m_tx_tdata, m_tx_tlast, e.data, e.last);
          end
        end
      end
      pacc = s_rx_tvalid && s_rx_tready;
      if (pacc) begin
        e.data = vecs[idx].data;
        e.last = vecs[idx].exp_last;
        sb.push_back(e);
        plast_exp = vecs[idx].exp_last;
        idx++;
      end
      cyc++;
    end
    if (cyc >= LIMIT) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d beats want %0d", idx, vecs.size());
    end
    @(negedge clk);
    s_rx_tvalid = 1'b0;
    s_rx_tlast  = 1'b0;
    m_tx_tready = 1'b1;
    vecs.delete();
    sb.delete();
  endtask

  initial begin
    rst         = 1'b1;
    cfg_len     = '0;
    s_rx_tdata  = '0;
    s_rx_tvalid = 1'b0;
    s_rx_tlast  = 1'b0;
    m_tx_tready = 1'b1;
    #12;
    chk("rst_valid", 32'(m_tx_tvalid), 32'd0);
    chk("rst_data", m_tx_tdata, 32'd0);
    chk("rst_last", 32'(m_tx_tlast), 32'd0);
    chk("rst_in_pkt", 32'(in_pkt), 32'd0);
    chk("rst_ready", 32'(s_rx_tready), 32'd1);
    chk("rst_pkts", 32'(stat_pkts), 32'd0);
    chk("rst_short", 32'(stat_short), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Length 4: tlast on 3, 7, 11.
    for (int i = 0; i < 12; i++)
      add(W'(i), 1'b0, LB'(3), (i % 4) == 3);
    run(1'b0);
    chk("len4_pkts", 32'(stat_pkts), 32'(st(3)));
    chk("len4_short", 32'(stat_short), 32'(st(0)));

    // Short packet: source tlast on 3rd beat, then 8 full beats.
    for (int i = 0; i < 11; i++)
      add(W'(32'h100 + i), i == 2, LB'(7), i == 2 || i == 10);
    run(1'b0);
    chk("short_pkts", 32'(stat_pkts), 32'(st(5)));
    chk("short_short", 32'(stat_short), 32'(st(1)));

    // Length change after 2 beats: packets of 6, 2, 2.
    for (int i = 0; i < 10; i++)
      add(W'(32'h200 + i), 1'b0, (i < 2) ? LB'(5) : LB'(1),
          i == 5 || i == 7 || i == 9);
    run(1'b0);
    chk("chg_pkts", 32'(stat_pkts), 32'(st(8)));

    // Backpressure, max length: tlast on 31 and 63.
    for (int i = 0; i < 64; i++)
      add(W'($urandom), 1'b0, LB'(31), i == 31 || i == 63);
    run(1'b1);
    chk("bp_pkts", 32'(stat_pkts), 32'(st(10)));

    // Length 1: every beat closes.
    for (int i = 0; i < 5; i++)
      add(W'(32'h300 + i), 1'b0, LB'(0), 1'b1);
    run(1'b0);
    chk("one_pkts", 32'(stat_pkts), 32'(st(15)));

    // Exact-length tlast at max length is not short.
    for (int i = 0; i < 32; i++)
      add(W'(32'h400 + i), i == 31, LB'(31), i == 31);
    run(1'b0);
    chk("exact_pkts", 32'(stat_pkts), 32'(st(16)));
    chk("exact_short", 32'(stat_short), 32'(st(1)));

    // Async reset two beats into an 8-word packet.
    @(negedge clk);
    cfg_len     = LB'(7);
    s_rx_tvalid = 1'b1;
    s_rx_tdata  = 32'h500;
    @(negedge clk);
    s_rx_tdata  = 32'h501;
    @(negedge clk);
    s_rx_tvalid = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(m_tx_tvalid), 32'd1);
    chk("pre_rst_in_pkt", 32'(in_pkt), 32'd1);
    chk("pre_rst_data", m_tx_tdata, 32'h501);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(m_tx_tvalid), 32'd0);
    chk("arst_in_pkt", 32'(in_pkt), 32'd0);
    chk("arst_data", m_tx_tdata, 32'd0);
    chk("arst_pkts", 32'(stat_pkts), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++)
      add(W'(32'h600 + i), 1'b0, LB'(7), i == 7);
    run(1'b0);
    chk("post_rst_pkts", 32'(stat_pkts), 32'(st(1)));
    chk("post_rst_short", 32'(stat_short), 32'(st(0)));
    chk("post_rst_in_pkt", 32'(in_pkt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_pkt_framer.md
# axis_pkt_framer

Upstream stage of the packet FIFO. Slices a continuous AXI-Stream sample flow into packets of a runtime-programmable word count, asserting `tlast` on the final word. A `tlast` from the source closes a packet early. The output is registered and sustains full throughput, so every packet reaching the packet FIFO is bounded to `cfg_len+1` words. The FIFO depth must exceed `2^LEN_BITS` when the FIFO is built without release-on-full.

## Interface
Parameters:
- `WIDTH`, 32: data width in bits.
- `LEN_BITS`, 5: width of the length field and word counter. Maximum packet length is `2^LEN_BITS` words.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `cfg_len`, in, `LEN_BITS`: packet length minus 1. Sampled on the first beat of each packet.
- `s_rx_tdata`, in, `WIDTH`: input data.
- `s_rx_tvalid`, in, 1: input valid.
- `s_rx_tlast`, in, 1: source end-of-packet, which forces the packet to close early.
- `s_rx_tready`, out, 1: input ready.
- `m_tx_tdata`, out, `WIDTH`: output data.
- `m_tx_tvalid`, out, 1: output valid.
- `m_tx_tlast`, out, 1: output end-of-packet.
- `m_tx_tready`, in, 1: output ready.
- `in_pkt`, out, 1: high when a packet is open, meaning at least one word has been accepted and its `tlast` has not been accepted yet.
- `stat_pkts`, out, 16: count of packets emitted. Wraps.
- `stat_short`, out, 16: count of packets closed by `s_rx_tlast` before reaching the programmed length. Wraps.

## Operation
- Accept condition: an input beat is accepted when `s_rx_tvalid && s_rx_tready`.
- Input ready: `s_rx_tready = !m_tx_tvalid || m_tx_tready`. This is combinational.
- Word counter `cnt` (`LEN_BITS` bits):
  - Resets to 0 and increments on each accepted beat.
  - Clears to 0 on any accepted beat that ends a packet.
- Length latch `len_q`:
  - On an accepted beat with `cnt==0`, `len_q <= cfg_len`.
  - The effective length for a beat is `eff = (cnt==0) ? cfg_len : len_q`.
  - `cfg_len` changes in the middle of a packet do not affect the open packet.
- End-of-packet detection: `end = s_rx_tlast || (cnt == eff)`.
- Output register, loaded on each accepted beat:
  - `m_tx_tdata <= s_rx_tdata`
  - `m_tx_tlast <= end`
  - `m_tx_tvalid <= 1`
- Valid clear: when there is an output handshake and no new accepted beat in the same cycle, `m_tx_tvalid <= 0`.
- `in_pkt` is set on an accepted beat with `!end` and cleared on an accepted beat with `end`.
- A `cfg_len` of 0 produces packets of one word each, every beat with `tlast=1`.
- `cfg_len = 2^LEN_BITS-1` produces the maximum length. The counter never wraps inside a packet, because `end` fires at `cnt == eff`.
- Short packets: when `s_rx_tlast` arrives with `cnt < eff`, the packet closes, `stat_short` increments, and the counter restarts at 0 for the next packet.
- Exact-length packets: when `s_rx_tlast` coincides with `cnt == eff`, this is a normal packet and is not counted as short.
- `stat_pkts` increments on each accepted beat with `end`. It counts at input acceptance, not at output.

## Timing
- Latency is 1 cycle from input accept to `m_tx_tvalid`.
- Throughput is one word per cycle while `m_tx_tready` is held high.
- Backpressure:
  - `m_tx_tready` low with `m_tx_tvalid` high drives `s_rx_tready` low in the same cycle.
  - Output data and `tlast` stay stable until the handshake.
  - There is no skid buffer, so the ready path is combinational from `m_tx_tready`.
- Values during and after reset:
  - `m_tx_tvalid=0`, `m_tx_tdata=0`, `m_tx_tlast=0`.
  - `in_pkt=0`, `cnt=0`, `len_q=0`.
  - `stat_pkts=0`, `stat_short=0`.
  - `s_rx_tready=1` combinationally.
- Reset in the middle of a packet discards the output register content and the open packet. The first accepted beat after reset starts a new packet.
- Simultaneous output handshake and input accept: the register reloads and `m_tx_tvalid` stays at 1.

## Configuration
- `AXIS_PKT_FRAMER_STATS_EN` defined: `stat_pkts` and `stat_short` are implemented as described above.
- Macro undefined: both stat ports are tied to 0 and their counters are not synthesized. Framing behaviour is identical in both cases.

## Test plan
- Length 4: `cfg_len=3`, 12 continuous beats with data 0..11 and `m_tx_tready=1` → three packets, `tlast` on data 3, 7 and 11. `stat_pkts=3`, `stat_short=0`. Output appears 1 cycle after input.
- Short packet: `cfg_len=7`, `s_rx_tlast` on the 3rd beat, then 8 more beats → packets of 3 and 8 words. `stat_short=1`, `stat_pkts=2`.
- Mid-packet length change: `cfg_len=5`, change to 1 after 2 beats, feed 10 beats → packets of 6, 2 and 2 words.
- Backpressure: `cfg_len=31`, random `m_tx_tready` at 50%, 64 beats → no data lost or duplicated, `tlast` on beats 31 and 63, data held stable while stalled.
- Boundaries: `cfg_len=0` with 5 beats → five 1-word packets. `cfg_len=31` with `s_rx_tlast` on beat 31 → one packet, `stat_short=0`.
- Reset: assert `rst` asynchronously after 2 beats of an 8-word packet → `m_tx_tvalid` drops immediately and `in_pkt=0`. The next 8 beats form a full 8-word packet. With the macro undefined, the stat ports read 0 throughout.
